// File: rtl/rs5_pkg.sv
// Shared types and constants for the core-side memory port arbiter.
package rs5_pkg;

  // Which requester owns the access whose response arrives next cycle.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_IF   = 2'd1,
    OWNER_LS   = 2'd2
  } arb_owner_e;

  // The shared memory returns read data this many cycles after acceptance.
  localparam int MEM_LATENCY = 1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch and the LSU.
// Data accesses win by default; a streak counter bounds how long fetch can
// be starved, and a registered owner steers the late read data back.
module mem_port_arbiter
  import rs5_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_stall_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic [3:0]  ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int STREAK_W = $clog2(DATA_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_BURST_MAX);

  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streakNext;
  arb_owner_e          r_owner;
  arb_owner_e          w_ownerNext;
  logic                w_ifGnt;
  logic                w_lsGnt;

  // Grant decision: the LSU wins unless fetch has waited through a full burst.
  // Nothing is granted while reset is held.
  always_comb begin
    w_ifGnt = 1'b0;
    w_lsGnt = 1'b0;
    if (!reset) begin
      if (ls_req_i && (!if_req_i || (r_streak < STREAK_MAX))) begin
        w_lsGnt = 1'b1;
      end else if (if_req_i) begin
        w_ifGnt = 1'b1;
      end
    end
  end

  // Memory-side mux: a fetch grant never writes, and an idle cycle drives no strobe.
  always_comb begin
    mem_req_o   = w_ifGnt | w_lsGnt;
    mem_we_o    = 4'b0000;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (w_lsGnt) begin
      mem_we_o    = ls_we_i;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end else if (w_ifGnt) begin
      mem_addr_o  = {if_addr_i[31:2], 2'b00};
    end
  end

  // Requester-facing grants, fetch stall and response routing.
  always_comb begin
    if_gnt_o    = w_ifGnt;
    ls_gnt_o    = w_lsGnt;
    if_stall_o  = if_req_i && !w_ifGnt && !reset;
    if_rvalid_o = (r_owner == OWNER_IF) && !reset;
    ls_rvalid_o = (r_owner == OWNER_LS) && !reset;
    if_rdata_o  = mem_rdata_i;
    ls_rdata_o  = mem_rdata_i;
  end

  // Next streak count and next owner from this cycle's grant.
  always_comb begin
    w_streakNext = r_streak;
    if (w_ifGnt || !if_req_i) begin
      w_streakNext = '0;
    end else if (w_lsGnt && (r_streak != STREAK_MAX)) begin
      w_streakNext = r_streak + STREAK_W'(1);
    end

    w_ownerNext = OWNER_NONE;
    if (w_ifGnt) begin
      w_ownerNext = OWNER_IF;
    end else if (w_lsGnt) begin
      w_ownerNext = OWNER_LS;
    end
  end

  // State registers; reset drops any response still owed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= '0;
      r_owner  <= OWNER_NONE;
    end else begin
      r_streak <= w_streakNext;
      r_owner  <= w_ownerNext;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural one-cycle memory.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_stall_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic [3:0]  ls_we_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] memArray [0:255];
  int          vectors;
  int          miscompares;
  logic [9:0]  expIfPattern;
  logic [4:0]  expIfPattern6;

  mem_port_arbiter #(.DATA_BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_stall_o(if_stall_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: always ready, byte-enabled writes, read data one cycle late.
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o == 4'b0000) begin
        mem_rdata_i <= memArray[mem_addr_o[9:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we_o[b]) memArray[mem_addr_o[9:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end
    end
  end

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic lsReq, input logic [3:0] lsWe,
                               input logic [31:0] lsAddr, input logic [31:0] lsWdata);
    if_req_i   = ifReq;
    if_addr_i  = ifAddr;
    ls_req_i   = lsReq;
    ls_we_i    = lsWe;
    ls_addr_i  = lsAddr;
    ls_wdata_i = lsWdata;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Directed sequence: each step drives just after a rising edge and checks at the falling edge.
  initial begin
    vectors     = 0;
    miscompares = 0;
    mem_rdata_i = 32'h0;
    for (int i = 0; i < 256; i++) memArray[i] = 32'hC0DE_0000 | 32'(i);
    reset = 1'b1;
    applyStimulus(1'b1, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0);

    // Reset held three cycles with both requesters active.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_if_gnt", 32'(if_gnt_o), 32'd0);
      checkOutput("rst_ls_gnt", 32'(ls_gnt_o), 32'd0);
      checkOutput("rst_mem_req", 32'(mem_req_o), 32'd0);
      checkOutput("rst_mem_we", 32'(mem_we_o), 32'd0);
      checkOutput("rst_stall", 32'(if_stall_o), 32'd0);
      checkOutput("rst_rvalids", {30'd0, if_rvalid_o, ls_rvalid_o}, 32'd0);
      nextCycle();
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rel_ls_gnt", 32'(ls_gnt_o), 32'd1);
    checkOutput("rel_if_gnt", 32'(if_gnt_o), 32'd0);
    checkOutput("rel_stall", 32'(if_stall_o), 32'd1);
    checkOutput("rel_rvalids", {30'd0, if_rvalid_o, ls_rvalid_o}, 32'd0);

    // Fetch-only stream at 0x0, 0x4, 0x8.
    nextCycle();
    applyStimulus(1'b1, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("f0_gnt", 32'(if_gnt_o), 32'd1);
    checkOutput("f0_stall", 32'(if_stall_o), 32'd0);
    checkOutput("f0_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    checkOutput("f0_if_rvalid", 32'(if_rvalid_o), 32'd0);
    checkOutput("f0_mem_addr", mem_addr_o, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h4, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("f1_gnt", 32'(if_gnt_o), 32'd1);
    checkOutput("f1_stall", 32'(if_stall_o), 32'd0);
    checkOutput("f1_rvalid", 32'(if_rvalid_o), 32'd1);
    checkOutput("f1_rdata", if_rdata_o, 32'hC0DE_0000);
    checkOutput("f1_mem_addr", mem_addr_o, 32'h4);
    nextCycle();
    applyStimulus(1'b1, 32'h8, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("f2_gnt", 32'(if_gnt_o), 32'd1);
    checkOutput("f2_stall", 32'(if_stall_o), 32'd0);
    checkOutput("f2_rvalid", 32'(if_rvalid_o), 32'd1);
    checkOutput("f2_rdata", if_rdata_o, 32'hC0DE_0001);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("f3_rvalid", 32'(if_rvalid_o), 32'd1);
    checkOutput("f3_rdata", if_rdata_o, 32'hC0DE_0002);
    checkOutput("f3_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("f3_ls_rvalid", 32'(ls_rvalid_o), 32'd0);

    // Both requesting for ten cycles: LSU writes 0x200, fetch reads 0xC.
    expIfPattern = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      nextCycle();
      applyStimulus(1'b1, 32'hC, 1'b1, 4'b1111, 32'h200, 32'h5A5A_5A5A);
      @(negedge clk);
      checkOutput($sformatf("burst%0d_if_gnt", i), 32'(if_gnt_o), 32'(expIfPattern[i]));
      checkOutput($sformatf("burst%0d_ls_gnt", i), 32'(ls_gnt_o), 32'(!expIfPattern[i]));
      checkOutput($sformatf("burst%0d_stall", i), 32'(if_stall_o), 32'(!expIfPattern[i]));
      if (expIfPattern[i]) begin
        checkOutput($sformatf("burst%0d_mem_we", i), 32'(mem_we_o), 32'd0);
        checkOutput($sformatf("burst%0d_mem_addr", i), mem_addr_o, 32'hC);
      end else begin
        checkOutput($sformatf("burst%0d_mem_we", i), 32'(mem_we_o), 32'hF);
        checkOutput($sformatf("burst%0d_mem_addr", i), mem_addr_o, 32'h200);
      end
    end

    // LSU half-word write to 0x100, then read it back.
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0011, 32'h100, 32'hA5A5_1234);
    @(negedge clk);
    checkOutput("wr_gnt", 32'(ls_gnt_o), 32'd1);
    checkOutput("wr_mem_we", 32'(mem_we_o), 32'h3);
    checkOutput("wr_mem_addr", mem_addr_o, 32'h100);
    checkOutput("wr_mem_wdata", mem_wdata_o, 32'hA5A5_1234);
    checkOutput("wr_if_rvalid", 32'(if_rvalid_o), 32'd1);
    checkOutput("wr_if_rdata", if_rdata_o, 32'hC0DE_0003);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 4'b0000, 32'h100, 32'h0);
    @(negedge clk);
    checkOutput("rd_gnt", 32'(ls_gnt_o), 32'd1);
    checkOutput("rd_mem_we", 32'(mem_we_o), 32'd0);
    checkOutput("wr_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("rd_ls_rvalid", 32'(ls_rvalid_o), 32'd1);
    checkOutput("rd_ls_rdata", ls_rdata_o, 32'hC0DE_1234);
    checkOutput("rd_if_rvalid", 32'(if_rvalid_o), 32'd0);

    // Fetch granted, then reset in the response cycle drops the response.
    nextCycle();
    applyStimulus(1'b1, 32'h8, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("pre_rst_if_gnt", 32'(if_gnt_o), 32'd1);
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_if_rvalid", 32'(if_rvalid_o), 32'd0);
    checkOutput("mid_rst_if_gnt", 32'(if_gnt_o), 32'd0);
    checkOutput("mid_rst_stall", 32'(if_stall_o), 32'd0);
    checkOutput("mid_rst_mem_req", 32'(mem_req_o), 32'd0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    @(negedge clk);
    checkOutput("post_rst_rvalids", {30'd0, if_rvalid_o, ls_rvalid_o}, 32'd0);

    // Three LSU grants against a waiting fetch, a fetch gap, then a fresh burst.
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      applyStimulus(1'b1, 32'h10, 1'b1, 4'b0000, 32'h40, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("pre_gap%0d_ls_gnt", i), 32'(ls_gnt_o), 32'd1);
    end
    nextCycle();
    applyStimulus(1'b0, 32'h10, 1'b1, 4'b0000, 32'h40, 32'h0);
    @(negedge clk);
    checkOutput("gap_ls_gnt", 32'(ls_gnt_o), 32'd1);
    checkOutput("gap_stall", 32'(if_stall_o), 32'd0);
    expIfPattern6 = 5'b1_0000;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      applyStimulus(1'b1, 32'h10, 1'b1, 4'b0000, 32'h40, 32'h0);
      @(negedge clk);
      checkOutput($sformatf("resume%0d_if_gnt", i), 32'(if_gnt_o), 32'(expIfPattern6[i]));
      checkOutput($sformatf("resume%0d_ls_gnt", i), 32'(ls_gnt_o), 32'(!expIfPattern6[i]));
    end

    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 4'b0000, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency memory between the fetch stage and the load/store unit. Data accesses win by default. A streak counter guarantees fetch a grant after a bounded run of back-to-back data grants. The block tracks the owner of the in-flight access and routes the one-cycle-late read data back to that owner. It sits between the core (fetch, LSU) and the shared memory, and its fetch stall output drives the fetch `enable_i`.

## Interface
Parameters:
- `DATA_BURST_MAX`, default 4: maximum consecutive data grants while fetch is waiting; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `if_req_i` in 1: fetch requests a read.
- `if_addr_i` in 32: fetch word address; bits [1:0] ignored.
- `if_gnt_o` out 1: fetch request accepted this cycle.
- `if_stall_o` out 1: `if_req_i && !if_gnt_o`; fetch deasserts its enable.
- `if_rvalid_o` out 1: fetch read data valid.
- `if_rdata_o` out 32: fetch read data.
- `ls_req_i` in 1: LSU request.
- `ls_we_i` in 4: byte write enables; 0 means read.
- `ls_addr_i` in 32: LSU address.
- `ls_wdata_i` in 32: LSU write data.
- `ls_gnt_o` out 1: LSU request accepted this cycle.
- `ls_rvalid_o` out 1: LSU access complete (read or write).
- `ls_rdata_o` out 32: LSU read data.
- `mem_req_o` out 1: memory access strobe.
- `mem_we_o` out 4: memory byte write enables.
- `mem_addr_o` out 32: memory address.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: memory read data, valid one cycle after `mem_req_o`.

## Operation
Memory model:
- Always ready.
- Accepts one access per cycle.
- Returns read data exactly one cycle after acceptance.

Arbitration (combinational, same cycle as request):
- Only `ls_req_i`: LSU granted.
- Only `if_req_i`: fetch granted.
- Both, and `streak < DATA_BURST_MAX`: LSU granted.
- Both, and `streak == DATA_BURST_MAX`: fetch granted.
- Neither: no grant. `mem_req_o` = 0, `mem_we_o` = 0.
- At most one grant per cycle.
- `mem_req_o` = `if_gnt_o || ls_gnt_o`.
- Memory address, write enable and write data mux from the granted side. A fetch grant forces `mem_we_o` = 0.

Streak counter (`$clog2(DATA_BURST_MAX+1)` bits, saturating):
- Increments on an LSU grant while `if_req_i` = 1.
- Clears to 0 on any fetch grant, and on any cycle with `if_req_i` = 0.
- Otherwise holds.

Owner register, states `OWNER_NONE`, `OWNER_IF`, `OWNER_LS`:
- Next state = granted side, or `OWNER_NONE` if no grant.
- Updates every cycle.

Response routing (registered owner, combinational data):
- `if_rvalid_o` = (owner == `OWNER_IF`).
- `ls_rvalid_o` = (owner == `OWNER_LS`). Asserted for writes as well.
- `if_rdata_o` and `ls_rdata_o` both equal `mem_rdata_i`. The owner qualifies them through rvalid.

## Timing
- Grant is zero-latency: the request in cycle N is granted in cycle N.
- Response is in cycle N+1. Back-to-back grants give one response per cycle with no bubble.
- Fetch worst-case wait with `ls_req_i` held high: `DATA_BURST_MAX` cycles, then granted.
- Reset (synchronous, checked at the clock edge):
  - Owner resets to `OWNER_NONE`; streak resets to 0.
  - While `reset` = 1, all grants, `mem_req_o`, `mem_we_o` and rvalids are 0, and `if_stall_o` = 0.
  - Data outputs pass `mem_rdata_i` through.
  - Reset asserted in the cycle after a grant: that response is dropped, with no rvalid.
- First cycle after reset deasserts: arbitration resumes. A fetch-only request is granted immediately.
- Simultaneous LSU write and fetch at the streak limit: fetch granted, the LSU write waits, and the memory sees no write that cycle.
- Requesters hold request, address and data stable until granted. The arbiter registers nothing from a request side.

## Structure
- `rs5_pkg`:
  - `typedef enum logic [1:0] arb_owner_e` with `OWNER_NONE` = 0, `OWNER_IF` = 1, `OWNER_LS` = 2.
  - Constant `MEM_LATENCY` = 1.
- Single module, no sub-modules. The streak counter and owner register are small enough to stay inline.
- Estimated 150–200 lines of RTL.

## Test plan
1. Reset held 3 cycles with `if_req_i` = `ls_req_i` = 1:
   - During reset: all grants, rvalids and `mem_req_o` = 0.
   - Cycle after release: `ls_gnt_o` = 1 (streak 0 < 4).
2. Fetch only, addresses 0x0, 0x4, 0x8 over consecutive cycles:
   - Grant every cycle.
   - `if_rvalid_o` one cycle later each, with `if_rdata_o` = memory contents.
   - `if_stall_o` never set.
3. `DATA_BURST_MAX` = 4, both requests held 10 cycles:
   - Grant pattern LS, LS, LS, LS, IF, LS, LS, LS, LS, IF.
   - `if_stall_o` high on the LS cycles.
4. LSU write (`ls_we_i` = 4'b0011, addr 0x100, wdata 0xA5A5_1234), then LSU read of 0x100:
   - `mem_we_o` = 0011 on the write.
   - `ls_rvalid_o` in the cycle after each grant.
   - Read returns 0xXXXX_1234 with the upper half unchanged.
5. Fetch granted in cycle N, `reset` asserted in N+1:
   - `if_rvalid_o` = 0 in N+1.
   - Owner = `OWNER_NONE` after release.
6. `if_req_i` drops for one cycle after 3 LS grants, then both requests resume:
   - Streak cleared.
   - Next 4 grants go to LS before the first IF grant.
